// File: rtl/scc_data_mem.sv
// scc_data_mem: sized little-endian load/store responder for the core data port.
// Line-crossing accesses take two array beats; the response is always registered.
`timescale 1ns/1ps
module scc_data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic [3:0]  err_bits
);

  localparam int unsigned AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [61:0] DEPTH_L = 62'(DEPTH_WORDS);

  typedef enum logic {
    ST_IDLE,
    ST_SPLIT
  } state_e;

  state_e      state_q;
  logic        rsp_valid_q;
  logic [63:0] rsp_rdata_q;
  logic [1:0]  err_q;

  logic        we_q;
  logic [63:0] wdata_q;
  logic [2:0]  lane_q;
  logic [3:0]  end_q;
  logic [61:0] line2_q;
  logic        below_q;
  logic [63:0] part_q;

  logic [63:0] mem [DEPTH_WORDS];

  function automatic logic [7:0] be_below(
    input logic [3:0] k
  );
    logic [7:0] be;
    for (int i = 0; i < 8; i++) begin
      be[i] = (4'(i) < k);
    end
    return be;
  endfunction

  function automatic logic [63:0] be_mask(
    input logic [7:0] be
  );
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  logic [63:0] off;
  logic        below;
  logic [61:0] line;
  logic [2:0]  lane;
  logic [3:0]  nbytes;
  logic [3:0]  lane_end;
  logic        split;

  assign off      = req_addr - BASE_ADDR;
  assign below    = req_addr < BASE_ADDR;
  assign line     = {1'b0, off[63:3]};
  assign lane     = off[2:0];
  assign nbytes   = 4'd1 << req_size;
  assign lane_end = {1'b0, lane} + nbytes;
  assign split    = lane_end > 4'd8;

  assign req_ready = (state_q == ST_IDLE) && !rst;

  logic          accept;
  logic [61:0]   acc_line;
  logic          acc_below;
  logic          acc_ok;
  logic [AW-1:0] acc_idx;
  logic [63:0]   acc_word;
  logic [5:0]    sh1;
  logic [5:0]    sh2;
  logic [7:0]    be1;
  logic [7:0]    be2;
  logic          wr_en;
  logic [7:0]    wr_be;
  logic [63:0]   wr_data;
  logic [63:0]   rd1;
  logic [63:0]   rd2;

  assign accept = req_valid && req_ready && clk_en;
  assign sh1    = {lane, 3'b000};
  // beat 2 picks up where beat 1 ran out: 8-lane bytes already consumed
  assign sh2    = {3'd0 - lane_q, 3'b000};
  assign be1    = be_below(lane_end) & ~be_below({1'b0, lane});
  assign be2    = be_below(end_q - 4'd8);

  always_comb begin
    acc_line  = line;
    acc_below = below;
    wr_en     = 1'b0;
    wr_be     = be1;
    wr_data   = req_wdata << sh1;
    if (state_q == ST_SPLIT) begin
      acc_line  = line2_q;
      acc_below = below_q;
      wr_be     = be2;
      wr_data   = wdata_q >> sh2;
    end
    acc_ok  = !acc_below && (acc_line < DEPTH_L);
    acc_idx = acc_line[AW-1:0];
    if (state_q == ST_SPLIT) begin
      wr_en = clk_en && !rst && we_q && acc_ok;
    end else begin
      wr_en = accept && req_we && acc_ok;
    end
  end

  assign acc_word = acc_ok ? mem[acc_idx] : '0;
  assign rd1 = (acc_word >> sh1) & be_mask(be_below(nbytes));
  assign rd2 = (acc_word & be_mask(be2)) << sh2;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_be[b]) begin
          mem[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= '0;
    end else if (clk_en) begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (!acc_ok) err_q[0] <= 1'b1;
            if (split) begin
              state_q <= ST_SPLIT;
              we_q    <= req_we;
              wdata_q <= req_wdata;
              lane_q  <= lane;
              end_q   <= lane_end;
              line2_q <= line + 62'd1;
              below_q <= below;
              part_q  <= req_we ? '0 : rd1;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= req_we ? '0 : rd1;
            end
          end
        end
        ST_SPLIT: begin
          if (!acc_ok) err_q[0] <= 1'b1;
          err_q[1]    <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= we_q ? '0 : (part_q | rd2);
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err_bits  = {2'b00, err_q};

endmodule

// File: tb/tb_scc_data_mem.sv
// tb_scc_data_mem: directed vector table, corner sequences and random
// traffic compared against a byte-array model of the data memory.
`timescale 1ns/1ps
module tb_scc_data_mem;

  localparam int unsigned DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h0;
  localparam int unsigned NB    = DEPTH * 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        req_valid;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_ready;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic [3:0]  err_bits;

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [NB];
  logic [3:0] m_err;

  scc_data_mem #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_size (req_size),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .err_bits (err_bits)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < 64'(NB));
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] a,
                                         input logic [1:0] sz);
    logic [63:0] r = '0;
    for (int i = 0; i < (1 << sz); i++) begin
      if (in_rng(a + 64'(i)))
        r[8*i +: 8] = mm[int'(a + 64'(i) - BASE)];
    end
    return r;
  endfunction

  task automatic m_store(input logic [63:0] a, input logic [63:0] d,
                         input logic [1:0] sz);
    for (int i = 0; i < (1 << sz); i++) begin
      if (in_rng(a + 64'(i)))
        mm[int'(a + 64'(i) - BASE)] = d[8*i +: 8];
    end
  endtask

  function automatic bit m_split(input logic [63:0] a,
                                 input logic [1:0] sz);
    return (int'((a - BASE) & 64'h7) + (1 << sz)) > 8;
  endfunction

  function automatic bit m_oor(input logic [63:0] a,
                               input logic [1:0] sz);
    bit o = 1'b0;
    for (int i = 0; i < (1 << sz); i++)
      if (!in_rng(a + 64'(i))) o = 1'b1;
    return o;
  endfunction

  function automatic logic [7:0] pat(input logic [63:0] a);
    return 8'(a * 37 + 11);
  endfunction

  task automatic xfer(input logic we, input logic [63:0] a,
                      input logic [63:0] d, input logic [1:0] sz,
                      output logic [63:0] rd, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_size  = sz;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd = rsp_rdata;
  endtask

  task automatic run(input string nm, input logic we,
                     input logic [63:0] a, input logic [63:0] d,
                     input logic [1:0] sz);
    logic [63:0] rd;
    logic [63:0] exp_rd;
    int lat;
    int exp_lat;
    exp_rd  = we ? 64'h0 : m_load(a, sz);
    exp_lat = m_split(a, sz) ? 2 : 1;
    xfer(we, a, d, sz, rd, lat);
    chk({nm, " data"}, rd, exp_rd);
    chk({nm, " lat"}, 64'(lat), 64'(exp_lat));
    if (we) m_store(a, d, sz);
    m_err = m_err | {2'b00, m_split(a, sz), m_oor(a, sz)};
  endtask

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  sz;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [63:0] w;
    logic [63:0] rd;
    int lat;

    tbl[0]  = '{1'b1, 64'h10, 64'h0123456789ABCDEF, 2'd3, 64'h0, 1};
    tbl[1]  = '{1'b0, 64'h10, 64'h0, 2'd3, 64'h0123456789ABCDEF, 1};
    tbl[2]  = '{1'b0, 64'h13, 64'h0, 2'd0, 64'h89, 1};
    tbl[3]  = '{1'b0, 64'h14, 64'h0, 2'd0, 64'h67, 1};
    tbl[4]  = '{1'b0, 64'h16, 64'h0, 2'd1, 64'h0123, 1};
    tbl[5]  = '{1'b1, 64'h11, 64'hAAAAAAAAAAAAAAFF, 2'd0, 64'h0, 1};
    tbl[6]  = '{1'b0, 64'h10, 64'h0, 2'd3, 64'h0123456789ABFFEF, 1};
    tbl[7]  = '{1'b1, 64'h1E, 64'h55555555DEADBEEF, 2'd2, 64'h0, 2};
    tbl[8]  = '{1'b0, 64'h1E, 64'h0, 2'd2, 64'hDEADBEEF, 2};
    tbl[9]  = '{1'b0, 64'h1E, 64'h0, 2'd1, 64'hBEEF, 1};
    tbl[10] = '{1'b0, 64'h20, 64'h0, 2'd1, 64'hDEAD, 1};
    tbl[11] = '{1'b0, 64'h1F, 64'h0, 2'd0, 64'hBE, 1};
    tbl[12] = '{1'b0, 64'h1F, 64'h0, 2'd1, 64'hADBE, 2};

    rst = 1'b1; clk_en = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_size = '0; m_err = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst err_bits", err_bits, 0);
    chk("rst ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst ready", req_ready, 1);

    for (int a = 0; a <= 'h100; a += 8) begin
      for (int i = 0; i < 8; i++) w[8*i +: 8] = pat(64'(a + i));
      run("init", 1'b1, 64'(a), w, 2'd3);
    end
    for (int a = 'h1FF0; a <= 'h1FF8; a += 8) begin
      for (int i = 0; i < 8; i++) w[8*i +: 8] = pat(64'(a + i));
      run("init hi", 1'b1, 64'(a), w, 2'd3);
    end

    foreach (tbl[k]) begin
      xfer(tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].sz, rd, lat);
      chk($sformatf("vec%0d data", k), rd, tbl[k].exp);
      chk($sformatf("vec%0d lat", k), 64'(lat), 64'(tbl[k].lat));
      if (tbl[k].we) m_store(tbl[k].addr, tbl[k].wdata, tbl[k].sz);
      m_err = m_err | {2'b00, m_split(tbl[k].addr, tbl[k].sz),
                       m_oor(tbl[k].addr, tbl[k].sz)};
    end
    chk("split sticky err", err_bits, 4'b0010);

    // clk_en low with a request waiting: nothing is accepted
    run("pre-idle st", 1'b1, 64'h48, 64'h1122334455667788, 2'd3);
    @(posedge clk);
    #1;
    chk("pulse one cycle", rsp_valid, 0);
    @(negedge clk);
    clk_en = 1'b0; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 64'h40; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    req_size = 2'd3;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("en0 no rsp", rsp_valid, 0);
    end
    @(negedge clk);
    req_valid = 1'b0; clk_en = 1'b1;
    run("en0 ld", 1'b0, 64'h40, 64'h0, 2'd3);

    // clk_en low in the middle of a split store
    run("pre-split st", 1'b1, 64'h41, 64'h0, 2'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h2E;
    req_wdata = 64'h11223344; req_size = 2'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t5 accept ready", req_ready, 0);
    chk("t5 accept rsp", rsp_valid, 0);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("t5 frz rsp", rsp_valid, 0);
      chk("t5 frz ready", req_ready, 0);
      chk("t5 frz rdata", rsp_rdata, 0);
    end
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    chk("t5 ack", rsp_valid, 1);
    chk("t5 ack rdata", rsp_rdata, 0);
    @(posedge clk);
    #1;
    chk("t5 ack drop", rsp_valid, 0);
    chk("t5 ready back", req_ready, 1);
    m_store(64'h2E, 64'h11223344, 2'd2);
    m_err[1] = 1'b1;
    run("t5 ld", 1'b0, 64'h2E, 64'h0, 2'd2);

    // reset while the second beat of a split store is pending
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h1E;
    req_wdata = 64'hCAFEF00D; req_size = 2'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t6 in split", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6 rst rsp", rsp_valid, 0);
    chk("t6 rst err", err_bits, 0);
    chk("t6 rst ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6 ready", req_ready, 1);
    @(posedge clk);
    #1;
    chk("t6 no rsp", rsp_valid, 0);
    mm[int'(64'h1E)] = 8'h0D;
    mm[int'(64'h1F)] = 8'hF0;
    m_err = '0;
    run("t6 ld lo", 1'b0, 64'h1E, 64'h0, 2'd1);
    run("t6 ld hi", 1'b0, 64'h20, 64'h0, 2'd1);

    // out-of-range access and a split straddling the array end
    run("oor ld", 1'b0, 64'(NB), 64'h0, 2'd3);
    chk("oor err", err_bits, 4'b0001);
    run("edge st", 1'b1, 64'(NB - 4), 64'hA1B2C3D4E5F60718, 2'd3);
    run("edge ld", 1'b0, 64'(NB - 4), 64'h0, 2'd2);
    chk("edge err", err_bits, 4'b0011);

    // back-to-back store then load of the same bytes
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h50;
    req_wdata = 64'hFEDCBA9876543210; req_size = 2'd3;
    @(posedge clk);
    #1;
    chk("b2b ready", req_ready, 1);
    chk("b2b st ack", rsp_valid, 1);
    chk("b2b st rdata", rsp_rdata, 0);
    req_we = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("b2b ld valid", rsp_valid, 1);
    chk("b2b ld rdata", rsp_rdata, 64'hFEDCBA9876543210);
    @(posedge clk);
    #1;
    chk("b2b idle", rsp_valid, 0);
    m_store(64'h50, 64'hFEDCBA9876543210, 2'd3);

    for (int n = 0; n < 300; n++) begin
      logic          r_we;
      logic [1:0]    r_sz;
      logic [63:0]   r_a;
      logic [63:0]   r_d;
      r_we = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        r_a = 64'(NB - 16) + 64'($urandom_range(0, 47));
      else
        r_a = 64'($urandom_range(0, 255));
      r_d = {$urandom, $urandom};
      run("rnd", r_we, r_a, r_d, r_sz);
    end
    chk("final err", err_bits, m_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
